// File: rtl/logic_lock_key_ctrl_if.sv
// Serial key-load handshake plus key and status outputs of the logic-lock key controller.
interface logic_lock_key_ctrl_if #(
  parameter int MUX_KW   = 4,
  parameter int XOR_KW   = 29,
  parameter int MAX_FAIL = 3
);
  localparam int FCW = $clog2(MAX_FAIL + 1);

  logic              load_start;
  logic              key_in_valid;
  logic              key_in_bit;
  logic              key_in_ready;
  logic              clear;
  logic [MUX_KW-1:0] mux_key;
  logic [XOR_KW-1:0] xor_key;
  logic              key_valid;
  logic              busy;
  logic              err;
  logic              lockout;
  logic [FCW-1:0]    fail_cnt;

  modport master (
    output load_start, key_in_valid, key_in_bit, clear,
    input  key_in_ready, mux_key, xor_key, key_valid, busy, err, lockout, fail_cnt
  );

  modport slave (
    input  load_start, key_in_valid, key_in_bit, clear,
    output key_in_ready, mux_key, xor_key, key_valid, busy, err, lockout, fail_cnt
  );
endinterface

// File: rtl/logic_lock_key_ctrl.sv
// Stages a serially loaded, CRC-8 protected unlock key and presents it to the locked netlist
// atomically; repeated bad keys latch a lockout that only reset releases.
module logic_lock_key_ctrl #(
  parameter int MUX_KW   = 4,
  parameter int XOR_KW   = 29,
  parameter int CRC_W    = 8,
  parameter int MAX_FAIL = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  logic_lock_key_ctrl_if.slave  kif
);
  localparam int KEY_W = MUX_KW + XOR_KW;
  localparam int FCW   = $clog2(MAX_FAIL + 1);
  localparam int KCW   = $clog2(KEY_W + 1);
  localparam int CCW   = $clog2(CRC_W + 1);
  localparam logic [CRC_W-1:0] POLY = CRC_W'(7);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT_KEY, S_SHIFT_CRC, S_CHECK, S_ACTIVE, S_LOCKOUT
  } state_t;

  state_t             state, state_nxt;
  logic [KEY_W-1:0]   stage, key_out;
  logic [CRC_W-1:0]   crc_run, crc_rx, crc_step;
  logic [KCW-1:0]     key_cnt;
  logic [CCW-1:0]     crc_cnt;
  logic [FCW-1:0]     fail_cnt, fail_inc;
  logic               key_valid, err;
  logic               ready, start, acc_key, acc_crc, pass, fail, zap;

  // Serial CRC update for the bit currently offered
  always_comb begin
    crc_step = {crc_run[CRC_W-2:0], 1'b0};
    if (crc_run[CRC_W-1] ^ kif.key_in_bit) crc_step = crc_step ^ POLY;
  end

  assign fail_inc = (fail_cnt == FCW'(MAX_FAIL)) ? fail_cnt : fail_cnt + FCW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    start     = 1'b0;
    acc_key   = 1'b0;
    acc_crc   = 1'b0;
    pass      = 1'b0;
    fail      = 1'b0;
    zap       = 1'b0;
    case (state)
      S_IDLE, S_ACTIVE: begin
        if (kif.load_start) begin
          start     = 1'b1;
          state_nxt = S_SHIFT_KEY;
        end
      end
      S_SHIFT_KEY: begin
        ready   = 1'b1;
        acc_key = kif.key_in_valid;
        if (acc_key && key_cnt == KCW'(KEY_W - 1)) state_nxt = S_SHIFT_CRC;
      end
      S_SHIFT_CRC: begin
        // One drain cycle after the last trailer bit before the compare
        ready   = (crc_cnt != CCW'(CRC_W));
        acc_crc = ready && kif.key_in_valid;
        if (!ready) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (crc_run == crc_rx) begin
          pass      = 1'b1;
          state_nxt = S_ACTIVE;
        end else begin
          fail      = 1'b1;
          state_nxt = (fail_inc == FCW'(MAX_FAIL)) ? S_LOCKOUT : S_IDLE;
        end
      end
      S_LOCKOUT: state_nxt = S_LOCKOUT;
      default:   state_nxt = S_IDLE;
    endcase
    // clear overrides any pending transfer, but a lockout is sticky
    if (kif.clear && state != S_LOCKOUT) begin
      state_nxt = S_IDLE;
      zap       = 1'b1;
      start     = 1'b0;
      acc_key   = 1'b0;
      acc_crc   = 1'b0;
      pass      = 1'b0;
      fail      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage   <= '0;
      crc_run <= '0;
      crc_rx  <= '0;
      key_cnt <= '0;
      crc_cnt <= '0;
    end else if (zap || start) begin
      stage   <= '0;
      crc_run <= '0;
      crc_rx  <= '0;
      key_cnt <= '0;
      crc_cnt <= '0;
    end else begin
      if (acc_key) begin
        stage   <= {stage[KEY_W-2:0], kif.key_in_bit};
        crc_run <= crc_step;
        key_cnt <= key_cnt + KCW'(1);
      end
      if (acc_crc) begin
        crc_rx  <= {crc_rx[CRC_W-2:0], kif.key_in_bit};
        crc_cnt <= crc_cnt + CCW'(1);
      end
    end
  end

  // Netlist-facing key only moves on the CHECK exit edge or a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_out   <= '0;
      key_valid <= 1'b0;
      err       <= 1'b0;
      fail_cnt  <= '0;
    end else begin
      if (zap) begin
        key_out   <= '0;
        key_valid <= 1'b0;
      end
      if (start) err <= 1'b0;
      if (pass) begin
        key_out   <= stage;
        key_valid <= 1'b1;
        fail_cnt  <= '0;
      end
      if (fail) begin
        key_out   <= '0;
        key_valid <= 1'b0;
        err       <= 1'b1;
        fail_cnt  <= fail_inc;
      end
    end
  end

  assign kif.key_in_ready = ready;
  assign kif.mux_key      = key_out[KEY_W-1 -: MUX_KW];
  assign kif.xor_key      = key_out[XOR_KW-1:0];
  assign kif.key_valid    = key_valid;
  assign kif.err          = err;
  assign kif.fail_cnt     = fail_cnt;
  assign kif.busy         = (state == S_SHIFT_KEY) || (state == S_SHIFT_CRC) || (state == S_CHECK);
  assign kif.lockout      = (state == S_LOCKOUT);

  a_key_stable_in_shift: assert property (@(posedge clk) disable iff (!rst_n)
    ((state == S_SHIFT_KEY || state == S_SHIFT_CRC) && !kif.clear) |=> $stable(key_out));

  a_lockout_sticky: assert property (@(posedge clk) disable iff (!rst_n)
    (state == S_LOCKOUT) |=> (state == S_LOCKOUT));
endmodule

// File: tb/tb_logic_lock_key_ctrl.sv
// Randomized bench for logic_lock_key_ctrl against a polynomial-division CRC model and a key/status model.
module tb_logic_lock_key_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  logic_lock_key_ctrl_if #(.MUX_KW(4), .XOR_KW(29), .MAX_FAIL(3)) kif ();

  logic_lock_key_ctrl #(.MUX_KW(4), .XOR_KW(29), .CRC_W(8), .MAX_FAIL(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  // Reference state: what the netlist should see and the status flags
  logic [32:0] m_key;
  logic        m_valid, m_err, m_lock;
  logic [1:0]  m_fail;

  // CRC as remainder of K * x^8 divided by x^8+x^2+x+1
  function automatic logic [7:0] crc_ref(input logic [32:0] k);
    logic [40:0] r;
    r = {k, 8'h00};
    for (int i = 40; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction

  function automatic logic [39:0] exp_vec(input logic b, input logic r);
    return {m_key, m_valid, m_err, m_fail, m_lock, b, r};
  endfunction

  function automatic logic [39:0] obs_vec();
    return {kif.mux_key, kif.xor_key, kif.key_valid, kif.err, kif.fail_cnt,
            kif.lockout, kif.busy, kif.key_in_ready};
  endfunction

  task automatic model_reset();
    m_key = '0; m_valid = 1'b0; m_err = 1'b0; m_lock = 1'b0; m_fail = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Full load from IDLE/ACTIVE; checks shift stability, the CHECK cycle and the result
  task automatic do_load(input string nm, input logic [32:0] key, input logic [7:0] crc,
                         input bit gappy, output int edges);
    logic [40:0] bits;
    int idx, guard, stable_bad;
    bit acc, started, v;
    bits = {key, crc};
    kif.load_start = 1'b1;
    cyc();
    kif.load_start = 1'b0;
    m_err = 1'b0;
    n_run++;
    if (obs_vec() !== exp_vec(1'b1, 1'b1)) begin
      n_fail++; $display("FAIL %s_start: got %h want %h", nm, obs_vec(), exp_vec(1'b1, 1'b1));
    end
    idx = 40; guard = 0; edges = 0; started = 0; stable_bad = 0;
    while (idx >= 0 && guard < 300) begin
      v = gappy ? (guard % 2 == 1) : 1'b1;
      kif.key_in_valid = v;
      kif.key_in_bit   = v ? bits[idx] : 1'($urandom);
      acc = v && kif.key_in_ready;
      cyc();
      guard++;
      if (acc) started = 1;
      if (started) edges++;
      if (acc) idx--;
      if ({kif.mux_key, kif.xor_key, kif.key_valid} !== {m_key, m_valid}) stable_bad++;
    end
    kif.key_in_valid = 1'b0;
    n_run++;
    if (idx >= 0 || stable_bad != 0) begin
      n_fail++; $display("FAIL %s_shift: bits_left %0d unstable_cycles %0d want -1 and 0", nm, idx, stable_bad);
    end
    cyc();
    n_run++;
    if (obs_vec() !== exp_vec(1'b1, 1'b0)) begin
      n_fail++; $display("FAIL %s_check_cycle: got %h want %h", nm, obs_vec(), exp_vec(1'b1, 1'b0));
    end
    if (crc == crc_ref(key)) begin
      m_key = key; m_valid = 1'b1; m_fail = '0;
    end else begin
      m_key = '0; m_valid = 1'b0; m_err = 1'b1;
      if (m_fail != 2'd3) m_fail = m_fail + 2'd1;
      if (m_fail == 2'd3) m_lock = 1'b1;
    end
    cyc();
    edges += 2;
    n_run++;
    if (obs_vec() !== exp_vec(1'b0, 1'b0)) begin
      n_fail++; $display("FAIL %s_result: got %h want %h", nm, obs_vec(), exp_vec(1'b0, 1'b0));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    kif.load_start = 1'b0; kif.key_in_valid = 1'b0; kif.key_in_bit = 1'b0; kif.clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_run++;
    if (obs_vec() !== exp_vec(1'b0, 1'b0)) begin
      n_fail++; $display("FAIL reset_hold: got %h want %h", obs_vec(), exp_vec(1'b0, 1'b0));
    end
    rst_n = 1'b1;
    cyc();
    n_run++;
    if (obs_vec() !== exp_vec(1'b0, 1'b0)) begin
      n_fail++; $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec(1'b0, 1'b0));
    end
  endtask

  task automatic test_zero_key_latency();
    int e;
    do_load("zero_key", 33'h0, 8'h00, 1'b0, e);
    n_run++;
    if (e !== 43) begin
      n_fail++; $display("FAIL zero_key_latency: key_valid at edge %0d want 43", e);
    end
  endtask

  task automatic test_msb_key();
    int e;
    do_load("msb_key", 33'h1_0000_0000, crc_ref(33'h1_0000_0000), 1'b1, e);
    n_run++;
    if (kif.mux_key !== 4'h8) begin
      n_fail++; $display("FAIL msb_key_mux: got %h want 8", kif.mux_key);
    end
  endtask

  task automatic test_bad_crc();
    int e;
    logic [32:0] k;
    do_load("bad_crc", 33'h0, 8'h01, 1'b0, e);
    k = {1'($urandom), 32'($urandom)};
    do_load("bad_crc_recover", k, crc_ref(k), 1'b0, e);
  endtask

  task automatic test_clear_keeps_status();
    int e;
    logic [32:0] k;
    k = {1'($urandom), 32'($urandom)};
    do_load("clr_status_bad", k, crc_ref(k) ^ 8'h5a, 1'b0, e);
    kif.clear = 1'b1;
    cyc();
    kif.clear = 1'b0;
    n_run++;
    if (obs_vec() !== exp_vec(1'b0, 1'b0)) begin
      n_fail++; $display("FAIL clear_keeps_status: got %h want %h", obs_vec(), exp_vec(1'b0, 1'b0));
    end
    do_load("clr_status_good", k, crc_ref(k), 1'b0, e);
  endtask

  task automatic test_random();
    int e;
    logic [32:0] k;
    logic [7:0]  c;
    for (int n = 0; n < 8; n++) begin
      // Junk bits while not ready must be ignored
      for (int j = 0; j < 3; j++) begin
        kif.key_in_valid = 1'b1; kif.key_in_bit = 1'($urandom);
        cyc();
      end
      kif.key_in_valid = 1'b0;
      n_run++;
      if (obs_vec() !== exp_vec(1'b0, 1'b0)) begin
        n_fail++; $display("FAIL random_idle_%0d: got %h want %h", n, obs_vec(), exp_vec(1'b0, 1'b0));
      end
      k = {1'($urandom), 32'($urandom)};
      c = crc_ref(k);
      if (m_fail < 2 && $urandom_range(0, 2) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
      do_load($sformatf("random_%0d", n), k, c, 1'($urandom), e);
    end
  endtask

  task automatic test_clear_mid_load();
    int e;
    logic [32:0] k;
    k = {1'($urandom), 32'($urandom)};
    do_load("clr_mid_setup", k, crc_ref(k), 1'b0, e);
    kif.load_start = 1'b1;
    cyc();
    kif.load_start = 1'b0;
    m_err = 1'b0;
    for (int j = 0; j < 10; j++) begin
      kif.key_in_valid = 1'b1; kif.key_in_bit = 1'($urandom);
      cyc();
    end
    n_run++;
    if (obs_vec() !== exp_vec(1'b1, 1'b1)) begin
      n_fail++; $display("FAIL clr_mid_shifting: got %h want %h", obs_vec(), exp_vec(1'b1, 1'b1));
    end
    kif.key_in_valid = 1'b0;
    kif.clear = 1'b1;
    cyc();
    kif.clear = 1'b0;
    m_key = '0; m_valid = 1'b0;
    n_run++;
    if (obs_vec() !== exp_vec(1'b0, 1'b0)) begin
      n_fail++; $display("FAIL clr_mid_result: got %h want %h", obs_vec(), exp_vec(1'b0, 1'b0));
    end
  endtask

  task automatic test_clear_and_start();
    int e;
    logic [32:0] k;
    k = {1'($urandom), 32'($urandom)};
    do_load("clr_start_setup", k, crc_ref(k), 1'b0, e);
    kif.clear = 1'b1; kif.load_start = 1'b1;
    cyc();
    kif.clear = 1'b0; kif.load_start = 1'b0;
    m_key = '0; m_valid = 1'b0;
    n_run++;
    if (obs_vec() !== exp_vec(1'b0, 1'b0)) begin
      n_fail++; $display("FAIL clr_start_edge: got %h want %h", obs_vec(), exp_vec(1'b0, 1'b0));
    end
    cyc();
    n_run++;
    if (obs_vec() !== exp_vec(1'b0, 1'b0)) begin
      n_fail++; $display("FAIL clr_start_after: got %h want %h", obs_vec(), exp_vec(1'b0, 1'b0));
    end
  endtask

  task automatic test_reset_mid_crc();
    logic [32:0] k;
    logic [40:0] bits;
    k = {1'($urandom), 32'($urandom)};
    bits = {k, crc_ref(k)};
    kif.load_start = 1'b1;
    cyc();
    kif.load_start = 1'b0;
    for (int i = 40; i >= 5; i--) begin
      kif.key_in_valid = 1'b1; kif.key_in_bit = bits[i];
      cyc();
    end
    kif.key_in_valid = 1'b0;
    n_run++;
    if (kif.busy !== 1'b1 || kif.key_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_inflight: busy %b ready %b want 1 1", kif.busy, kif.key_in_ready);
    end
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    n_run++;
    if (obs_vec() !== exp_vec(1'b0, 1'b0)) begin
      n_fail++; $display("FAIL rst_mid_async: got %h want %h", obs_vec(), exp_vec(1'b0, 1'b0));
    end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_lockout();
    int e;
    logic [32:0] k;
    for (int n = 0; n < 3; n++) begin
      k = {1'($urandom), 32'($urandom)};
      do_load($sformatf("lock_bad_%0d", n), k, ~crc_ref(k), 1'b0, e);
    end
    kif.load_start = 1'b1;
    cyc();
    kif.load_start = 1'b0;
    kif.key_in_valid = 1'b1; kif.key_in_bit = 1'b1;
    cyc();
    kif.key_in_valid = 1'b0;
    n_run++;
    if (obs_vec() !== exp_vec(1'b0, 1'b0)) begin
      n_fail++; $display("FAIL lockout_load_start: got %h want %h", obs_vec(), exp_vec(1'b0, 1'b0));
    end
    kif.clear = 1'b1;
    cyc();
    kif.clear = 1'b0;
    n_run++;
    if (obs_vec() !== exp_vec(1'b0, 1'b0)) begin
      n_fail++; $display("FAIL lockout_clear: got %h want %h", obs_vec(), exp_vec(1'b0, 1'b0));
    end
    #2 rst_n = 1'b0;
    model_reset();
    #2;
    n_run++;
    if (obs_vec() !== exp_vec(1'b0, 1'b0)) begin
      n_fail++; $display("FAIL lockout_reset: got %h want %h", obs_vec(), exp_vec(1'b0, 1'b0));
    end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_zero_key_latency();
    test_msb_key();
    test_bad_crc();
    test_clear_keeps_status();
    test_random();
    test_clear_mid_load();
    test_clear_and_start();
    test_reset_mid_crc();
    test_lockout();
    test_bad_crc();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_run);
    $fatal(1);
  end
endmodule

// File: doc/logic_lock_key_ctrl.md
Name: logic_lock_key_ctrl

Overview:
- Loads, verifies and applies the unlock key for a logic-locked combinational benchmark netlist.
- The netlist takes a 4-bit mux-select key (p1..p4) and a 29-bit XOR key (X_1..X_29).
- The key arrives serially with a CRC-8 trailer. It is staged internally, checked, then presented to the netlist atomically.
- Repeated bad keys force a permanent lockout until reset.

Parameters:
- MUX_KW, 4, width of mux-select key (p1..pN).
- XOR_KW, 29, width of XOR key (X_1..X_N).
- CRC_W, 8, trailer width; polynomial fixed at x^8+x^2+x+1 (0x07).
- MAX_FAIL, 3, consecutive failed checks before LOCKOUT.

Ports:
- clk  in  1  single clock; all state rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  begin a key load; honoured only in IDLE/ACTIVE.
- key_in_valid  in  1  serial bit valid.
- key_in_bit  in  1  serial key/CRC bit.
- key_in_ready  out  1  high in SHIFT_KEY/SHIFT_CRC.
- clear  in  1  zeroize key outputs and staging.
- mux_key  out  MUX_KW  drives p1..p4; bit0=p1.
- xor_key  out  XOR_KW  drives X_1..X_29; bit0=X_1.
- key_valid  out  1  outputs hold a CRC-verified key.
- busy  out  1  state in SHIFT_KEY/SHIFT_CRC/CHECK.
- err  out  1  last check failed; cleared on next accepted load_start.
- lockout  out  1  LOCKOUT state.
- fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failures.

Behaviour:
- Reset values: all outputs 0; state IDLE; staging, CRC and counters 0.
- KEY_W = MUX_KW+XOR_KW = 33. K = {mux_key, xor_key}.
- Bit order: the first key bit received lands in K[KEY_W-1] (left shift).
- Handshake: a bit is accepted on a rising edge with key_in_valid && key_in_ready. key_in_valid while not ready is ignored.
- IDLE/ACTIVE + load_start -> SHIFT_KEY. Clears staging, running CRC (init 0x00), bit counter and err. Outputs and key_valid are retained.
- SHIFT_KEY: each accepted bit shifts into staging and updates the serial CRC (feedback = crc[7]^bit). After the KEY_W-th bit -> SHIFT_CRC.
- SHIFT_CRC: CRC_W bits accepted MSB first into the received-CRC register. After the last one -> CHECK.
- CHECK (exactly 1 cycle): compare running CRC with received CRC.
  - Pass: on the exit edge, staging -> mux_key/xor_key, key_valid=1, fail_cnt=0 -> ACTIVE.
  - Fail: on the exit edge, outputs zeroed, key_valid=0, err=1, fail_cnt+1.
    - fail_cnt reaches MAX_FAIL -> LOCKOUT.
    - Otherwise -> IDLE.
- Latency: key_valid rises on the 2nd rising edge after the edge that accepts the last CRC bit.
- Outputs never change during SHIFT_*. The netlist never sees a partial key.
- load_start while busy or in LOCKOUT: ignored.
- LOCKOUT: key_in_ready=0, outputs 0, key_valid=0, lockout=1. Exit only via rst_n.
- clear: priority over everything except rst_n.
  - Any state except LOCKOUT -> IDLE; zeroes outputs, staging and key_valid.
  - err and fail_cnt are retained.
  - In LOCKOUT: no effect.
- clear and load_start in the same cycle: clear wins; load_start is dropped.
- rst_n asserted mid-load: immediate return to reset values; partial key discarded.
- fail_cnt saturates at MAX_FAIL.

Test Plan:
- Reset, then load 33 zero bits + CRC 0x00 with continuous valid -> key_valid=1 at edge 43 after first acceptance; mux_key=4'h0, xor_key=0, err=0, fail_cnt=0.
- Load K=33'h1_0000_0000 (first bit 1, rest 0) with the model-computed CRC, valid toggled every other cycle -> mux_key=4'h8, xor_key=0, key_valid=1; outputs stable at the old value throughout the shift.
- Load the all-zero key with CRC 0x01 -> err=1, fail_cnt=1, key_valid=0, outputs 0, state IDLE; then a correct load -> err=0, fail_cnt=0, key_valid=1.
- Three consecutive bad loads -> lockout=1, key_in_ready=0. A subsequent load_start and clear have no effect; rst_n pulse returns all outputs to 0.
- From ACTIVE with a valid key, assert load_start, then clear after 10 bits -> IDLE, outputs 0, key_valid=0. Also assert rst_n low mid-SHIFT_CRC -> all outputs 0 asynchronously.
- Same-cycle clear+load_start in ACTIVE -> IDLE, busy stays 0, key_valid=0.
